mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arb_timer.sv | 26 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port
// indices, error data and the per-port request bundle.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int          NUM_PORTS  = 2;
    localparam logic        PORT_DATA  = 1'b0;
    localparam logic        PORT_FETCH = 1'b1;
    localparam logic [31:0] ERR_DATA   = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  msk;
    } port_req_t;

    // Round-robin only matters under contention; a lone requester always wins.
    function automatic logic pick_port(input logic [1:0] pend, input logic last_served);
        if (pend == 2'b11)
            return ~last_served;
        return pend[1] & ~pend[0];
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Memory-ack wait counter: cleared while idle, counts BUSY cycles without ack,
// flags expiry in the cycle the count reaches TIMEOUT.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 8'd1;
    end

    assign expire = inc && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (port 0 data, port 1 fetch) with round-robin
// grant, one outstanding memory transaction and an ack timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        m0_read_req,
    input  logic        m0_write_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_write_msk,
    output logic        m0_read_ack,
    output logic        m0_write_ack,
    output logic [31:0] m0_read_data,

    input  logic        m1_read_req,
    input  logic        m1_write_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_write_msk,
    output logic        m1_read_ack,
    output logic        m1_write_ack,
    output logic [31:0] m1_read_data,

    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_msk,
    input  logic        mem_read_ack,
    input  logic        mem_write_ack,
    input  logic [31:0] mem_read_data,

    output logic        bus_err
);

    arb_state_t                            state;
    logic                                  owner;
    logic                                  last_served;
    logic [NUM_PORTS-1:0]                  rd_req, wr_req, pend;
    logic [NUM_PORTS-1:0]                  rd_ack_q, wr_ack_q;
    logic [NUM_PORTS-1:0][31:0]            rdata_q;
    port_req_t [NUM_PORTS-1:0]             port_req;
    logic                                  grant;
    logic                                  ack_hit;
    logic                                  expire;

    assign rd_req   = {m1_read_req,  m0_read_req};
    assign wr_req   = {m1_write_req, m0_write_req};
    assign pend     = rd_req | wr_req;
    assign grant    = pick_port(pend, last_served);

    assign port_req[PORT_DATA]  = '{addr: m0_addr, data: m0_write_data, msk: m0_write_msk};
    assign port_req[PORT_FETCH] = '{addr: m1_addr, data: m1_write_data, msk: m1_write_msk};

    // Only the ack matching the in-flight op counts; the other type is noise.
    assign ack_hit  = (state == BUSY) &&
                      ((mem_read_req && mem_read_ack) || (mem_write_req && mem_write_ack));

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (state == IDLE),
        .inc    ((state == BUSY) && !ack_hit),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            owner          <= PORT_DATA;
            last_served    <= PORT_FETCH;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_msk  <= '0;
            rd_ack_q       <= '0;
            wr_ack_q       <= '0;
            rdata_q        <= '0;
            bus_err        <= 1'b0;
        end else begin
            rd_ack_q <= '0;
            wr_ack_q <= '0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pend) begin
                        // Read wins when a port raises both; its write stays pending.
                        owner          <= grant;
                        mem_read_req   <= rd_req[grant];
                        mem_write_req  <= ~rd_req[grant];
                        mem_addr       <= port_req[grant].addr;
                        mem_write_data <= port_req[grant].data;
                        mem_write_msk  <= port_req[grant].msk;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (ack_hit || expire) begin
                        mem_read_req  <= 1'b0;
                        mem_write_req <= 1'b0;
                        state         <= DONE;
                        if (mem_write_req)
                            wr_ack_q[owner] <= 1'b1;
                        else
                            rd_ack_q[owner] <= 1'b1;
                        if (!ack_hit) begin
                            rdata_q[owner] <= ERR_DATA;
                            bus_err        <= 1'b1;
                        end else if (mem_read_req) begin
                            rdata_q[owner] <= mem_read_data;
                        end
                    end
                end
                DONE: begin
                    last_served <= owner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_read_ack  = rd_ack_q[PORT_DATA];
    assign m0_write_ack = wr_ack_q[PORT_DATA];
    assign m0_read_data = rdata_q[PORT_DATA];
    assign m1_read_ack  = rd_ack_q[PORT_FETCH];
    assign m1_write_ack = wr_ack_q[PORT_FETCH];
    assign m1_read_data = rdata_q[PORT_FETCH];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, a
// monitor pops them when the DUT acks and checks the memory side while busy.
module tb_mem_arbiter;

    logic        clk, rstn;
    logic        m0_read_req, m0_write_req, m1_read_req, m1_write_req;
    logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
    logic [3:0]  m0_write_msk, m1_write_msk;
    logic        m0_read_ack, m0_write_ack, m1_read_ack, m1_write_ack;
    logic [31:0] m0_read_data, m1_read_data;
    logic        mem_read_req, mem_write_req, mem_read_ack, mem_write_ack;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_write_msk;
    logic        bus_err;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_addr(m0_addr),
        .m0_write_data(m0_write_data), .m0_write_msk(m0_write_msk),
        .m0_read_ack(m0_read_ack), .m0_write_ack(m0_write_ack), .m0_read_data(m0_read_data),
        .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_addr(m1_addr),
        .m1_write_data(m1_write_data), .m1_write_msk(m1_write_msk),
        .m1_read_ack(m1_read_ack), .m1_write_ack(m1_write_ack), .m1_read_data(m1_read_data),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_write_msk(mem_write_msk),
        .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack), .mem_read_data(mem_read_data),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  acks;   // {bus_err, m1_w, m1_r, m0_w, m0_r}
        logic [31:0] rdata;
        logic [1:0]  mreq;   // {write, read}
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  msk;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;
    logic        bogus    = 1'b0;
    int          busy_len = 0;
    logic [31:0] last_rd[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_line(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event with nothing expected", name);
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
    endfunction

    task automatic push(input logic [4:0] acks, input logic [31:0] rdata, input logic [1:0] mreq,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] msk);
        exp_t e;
        e.acks = acks; e.rdata = rdata; e.mreq = mreq;
        e.addr = addr; e.wdata = wdata; e.msk = msk;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int port, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] msk);
        if (port == 0) begin
            m0_read_req = rd; m0_write_req = wr; m0_addr = addr; m0_write_data = wdata; m0_write_msk = msk;
        end else begin
            m1_read_req = rd; m1_write_req = wr; m1_addr = addr; m1_write_data = wdata; m1_write_msk = msk;
        end
    endtask

    // Holds each request until its own ack, as a real requester would.
    task automatic run(input string name, input int budget);
        int n = 0;
        while ((m0_read_req || m0_write_req || m1_read_req || m1_write_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (m0_read_ack)  m0_read_req  = 1'b0;
            if (m0_write_ack) m0_write_req = 1'b0;
            if (m1_read_ack)  m1_read_req  = 1'b0;
            if (m1_write_ack) m1_write_req = 1'b0;
        end
        if (m0_read_req || m0_write_req || m1_read_req || m1_write_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: requests still pending after %0d cycles, required none", name, budget);
            m0_read_req = 0; m0_write_req = 0; m1_read_req = 0; m1_write_req = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    // Memory responder: acks after mem_lat BUSY cycles (0 = never).
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        mem_read_ack = 0; mem_write_ack = 0; mem_read_data = '0;
        forever begin
            @(negedge clk);
            mem_read_ack = 1'b0;
            mem_write_ack = 1'b0;
            if (!rstn || !(mem_read_req || mem_write_req)) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                busy_len = wait_cnt;
                if (bogus && wait_cnt == 1 && mem_lat != 1) begin
                    mem_read_ack  = mem_write_req;
                    mem_write_ack = mem_read_req;
                    mem_read_data = 32'hBAD0_BAD0;
                end
                if (mem_lat != 0 && wait_cnt == mem_lat) begin
                    mem_read_ack  = mem_read_req;
                    mem_write_ack = mem_write_req;
                    mem_read_data = mem_model(mem_addr);
                end
            end
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_rd[0] = '0;
                last_rd[1] = '0;
            end else begin
                act = {bus_err, m1_write_ack, m1_read_ack, m0_write_ack, m0_read_ack};
                if (mem_read_req || mem_write_req) begin
                    if (exp_q.size() == 0) fail_line("mem_req_unexpected");
                    else begin
                        check("mem_req_type", 64'({mem_write_req, mem_read_req}), 64'(exp_q[0].mreq));
                        check("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                        check("mem_write_data", 64'(mem_write_data), 64'(exp_q[0].wdata));
                        check("mem_write_msk", 64'(mem_write_msk), 64'(exp_q[0].msk));
                    end
                end
                if (act != '0) begin
                    if (exp_q.size() == 0) fail_line("ack_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("ack_vector", 64'(act), 64'(e.acks));
                        if (e.acks[0]) last_rd[0] = e.rdata;
                        if (e.acks[2]) last_rd[1] = e.rdata;
                        check("m0_read_data", 64'(m0_read_data), 64'(last_rd[0]));
                        check("m1_read_data", 64'(m1_read_data), 64'(last_rd[1]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        rstn = 1'b0;
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        #12;
        check("reset_ctrl", 64'({mem_read_req, mem_write_req, bus_err, m0_read_ack, m0_write_ack,
                                 m1_read_ack, m1_write_ack}), 64'(0));
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        check("reset_mem_wdata_msk", 64'({mem_write_data, mem_write_msk}), 64'(0));
        check("reset_read_data", {m0_read_data, m1_read_data}, 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Contention from reset: port 0 first, then port 1.
        mem_lat = 2;
        drive(0, 1, 0, 32'h300, '0, '0);
        drive(1, 1, 0, 32'h400, '0, '0);
        push(5'b00001, 32'h0300_C0DE, 2'b01, 32'h300, '0, '0);
        push(5'b00100, 32'h0400_C0DE, 2'b01, 32'h400, '0, '0);
        run("contention_1", 40);

        // Single read, ack on third BUSY cycle.
        mem_lat = 3;
        drive(0, 1, 0, 32'h100, '0, '0);
        push(5'b00001, 32'hDEAD_BEEF, 2'b01, 32'h100, '0, '0);
        run("read_0x100", 40);
        check("busy_len_read", 64'(busy_len), 64'(3));

        // Port 0 served last, so port 1 wins this contention.
        mem_lat = 2;
        drive(0, 1, 0, 32'h500, '0, '0);
        drive(1, 1, 0, 32'h600, '0, '0);
        push(5'b00100, 32'h0600_C0DE, 2'b01, 32'h600, '0, '0);
        push(5'b00001, 32'h0500_C0DE, 2'b01, 32'h500, '0, '0);
        run("contention_2", 40);

        // Port 1 write with a stray read ack that must be ignored.
        bogus = 1'b1;
        drive(1, 0, 1, 32'h200, 32'h55AA_55AA, 4'b0011);
        push(5'b01000, 32'h0, 2'b10, 32'h200, 32'h55AA_55AA, 4'b0011);
        run("write_0x200", 40);
        check("busy_len_write", 64'(busy_len), 64'(2));
        bogus = 1'b0;

        // Ack in the very cycle the counter reaches TIMEOUT: normal completion.
        mem_lat = 4;
        drive(0, 1, 0, 32'h700, '0, '0);
        push(5'b00001, 32'h0700_C0DE, 2'b01, 32'h700, '0, '0);
        run("ack_at_limit", 40);
        check("busy_len_limit", 64'(busy_len), 64'(4));

        // No ack: timeout after 4 BUSY cycles with error data and bus_err.
        mem_lat = 0;
        drive(0, 1, 0, 32'h800, '0, '0);
        push(5'b10001, 32'hFFFF_FFFF, 2'b01, 32'h800, '0, '0);
        run("timeout", 40);
        check("busy_len_timeout", 64'(busy_len), 64'(4));

        // Read and write together: read first, write afterwards, minimum latency.
        mem_lat = 1;
        drive(0, 1, 1, 32'h900, 32'h1234_5678, 4'b1111);
        push(5'b00001, 32'h0900_C0DE, 2'b01, 32'h900, 32'h1234_5678, 4'b1111);
        push(5'b00010, 32'h0, 2'b10, 32'h900, 32'h1234_5678, 4'b1111);
        run("read_write_same_port", 40);
        check("busy_len_min", 64'(busy_len), 64'(1));

        // Reset in the middle of BUSY: mem req drops without a clock edge.
        mem_lat = 0;
        drive(0, 1, 0, 32'hB00, '0, '0);
        push(5'b00001, 32'h0, 2'b01, 32'hB00, '0, '0);
        n = 0;
        while (!mem_read_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_before_reset", 64'(mem_read_req), 64'(1));
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_mem_req", 64'({mem_read_req, mem_write_req}), 64'(0));
        check("async_reset_acks", 64'({m0_read_ack, m0_write_ack, bus_err}), 64'(0));
        m0_read_req = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("reset_read_data_clear", 64'(m0_read_data), 64'(0));
        rstn = 1'b1;
        @(negedge clk);

        mem_lat = 2;
        drive(0, 1, 0, 32'hA00, '0, '0);
        push(5'b00001, 32'h0A00_C0DE, 2'b01, 32'hA00, '0, '0);
        run("post_reset_read", 40);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
